// File: rtl/mc_ctrl.sv
// Multi-cycle control sequencer for the MIPS datapath: walks each instruction through
// IF/ID/EX/MEM/WB so that every architectural write enable is high for exactly one cycle.
module mc_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       equal,
    input  logic       mem_rdy,
    output logic       IRWr,
    output logic       PCWr,
    output logic [2:0] PCSrc,
    output logic       RegDst,
    output logic       RegWr,
    output logic       ExtOp,
    output logic       ALUSrc,
    output logic [5:0] ALUCtr,
    output logic       MemWr,
    output logic       MemtoReg,
    output logic       inst_done,
    output logic       illegal,
    output logic       mem_err,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    typedef enum logic [4:0] {
        C_NOP   = 5'd0,
        C_ADDU  = 5'd1,
        C_SUBU  = 5'd2,
        C_AND   = 5'd3,
        C_OR    = 5'd4,
        C_SLT   = 5'd5,
        C_SLL   = 5'd6,
        C_SRL   = 5'd7,
        C_JR    = 5'd8,
        C_ADDIU = 5'd9,
        C_ORI   = 5'd10,
        C_LUI   = 5'd11,
        C_LW    = 5'd12,
        C_SW    = 5'd13,
        C_BEQ   = 5'd14,
        C_BNE   = 5'd15,
        C_J     = 5'd16
    } iclass_t;

    state_t             state_q, state_d;
    iclass_t            class_q, class_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    iclass_t dec_class;
    logic    dec_ok;
    logic    mem_timeout;
    logic    is_rtype;

    always_comb begin
        dec_class = C_NOP;
        dec_ok    = 1'b1;
        case (op)
            6'b000000: begin
                case (funct)
                    6'b100001: dec_class = C_ADDU;
                    6'b100011: dec_class = C_SUBU;
                    6'b100100: dec_class = C_AND;
                    6'b100101: dec_class = C_OR;
                    6'b101010: dec_class = C_SLT;
                    6'b000000: dec_class = C_SLL;
                    6'b000010: dec_class = C_SRL;
                    6'b001000: dec_class = C_JR;
                    default:   dec_ok    = 1'b0;
                endcase
            end
            6'b001001: dec_class = C_ADDIU;
            6'b001101: dec_class = C_ORI;
            6'b001111: dec_class = C_LUI;
            6'b100011: dec_class = C_LW;
            6'b101011: dec_class = C_SW;
            6'b000100: dec_class = C_BEQ;
            6'b000101: dec_class = C_BNE;
            6'b000010: dec_class = C_J;
            default:   dec_ok    = 1'b0;
        endcase
    end

    // The MEM cycle holding cnt_q == MEM_TIMEOUT-1 is the last one allowed; ready there still wins.
    assign mem_timeout = !mem_rdy && (cnt_q == CNT_W'(MEM_TIMEOUT - 1));
    assign is_rtype    = class_q inside {C_ADDU, C_SUBU, C_AND, C_OR, C_SLT, C_SLL, C_SRL};

    always_comb begin
        state_d = state_q;
        class_d = class_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IF: state_d = S_ID;
            S_ID: begin
                class_d = dec_ok ? dec_class : C_NOP;
                state_d = S_EX;
            end
            S_EX: begin
                if (class_q inside {C_LW, C_SW}) begin
                    cnt_d   = '0;
                    state_d = S_MEM;
                end else if (is_rtype || class_q inside {C_ADDIU, C_ORI, C_LUI}) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_IF;
                end
            end
            S_MEM: begin
                if (mem_rdy) begin
                    state_d = (class_q == C_LW) ? S_WB : S_IF;
                end else if (mem_timeout) begin
                    state_d = S_IF;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WB:    state_d = S_IF;
            default: state_d = S_IF;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IF;
            class_q <= C_NOP;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            class_q <= class_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs follow state and latched class; reset forces them low without waiting for an edge.
    always_comb begin
        IRWr      = 1'b0;
        PCWr      = 1'b0;
        PCSrc     = 3'b000;
        RegDst    = 1'b0;
        RegWr     = 1'b0;
        ExtOp     = 1'b0;
        ALUSrc    = 1'b0;
        ALUCtr    = 6'd0;
        MemWr     = 1'b0;
        MemtoReg  = 1'b0;
        inst_done = 1'b0;
        illegal   = 1'b0;
        mem_err   = 1'b0;
        if (!rst) begin
            if (state_q inside {S_EX, S_MEM, S_WB}) begin
                case (class_q)
                    C_SUBU:  ALUCtr = 6'd1;
                    C_AND:   ALUCtr = 6'd2;
                    C_OR:    ALUCtr = 6'd3;
                    C_SLT:   ALUCtr = 6'd4;
                    C_SLL:   ALUCtr = 6'd5;
                    C_SRL:   ALUCtr = 6'd6;
                    C_ADDIU: begin ALUSrc = 1'b1; ExtOp = 1'b1; end
                    C_ORI:   begin ALUSrc = 1'b1; ALUCtr = 6'd3; end
                    C_LUI:   begin ALUSrc = 1'b1; ALUCtr = 6'd7; end
                    C_LW, C_SW: begin ALUSrc = 1'b1; ExtOp = 1'b1; end
                    C_BEQ, C_BNE: ALUCtr = 6'd1;
                    default: ALUCtr = 6'd0;
                endcase
            end
            case (state_q)
                S_IF: IRWr = 1'b1;
                S_ID: illegal = !dec_ok;
                S_EX: begin
                    case (class_q)
                        C_BEQ: begin PCWr = 1'b1; inst_done = 1'b1; PCSrc = equal ? 3'b001 : 3'b000; end
                        C_BNE: begin PCWr = 1'b1; inst_done = 1'b1; PCSrc = equal ? 3'b000 : 3'b001; end
                        C_J:   begin PCWr = 1'b1; inst_done = 1'b1; PCSrc = 3'b010; end
                        C_JR:  begin PCWr = 1'b1; inst_done = 1'b1; PCSrc = 3'b011; end
                        C_NOP: begin PCWr = 1'b1; inst_done = 1'b1; end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    if (mem_rdy) begin
                        if (class_q == C_SW) begin
                            MemWr     = 1'b1;
                            PCWr      = 1'b1;
                            inst_done = 1'b1;
                        end
                    end else if (mem_timeout) begin
                        mem_err = 1'b1;
                        PCWr    = 1'b1;
                    end
                end
                S_WB: begin
                    RegWr     = 1'b1;
                    RegDst    = is_rtype;
                    MemtoReg  = (class_q == C_LW);
                    PCWr      = 1'b1;
                    inst_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_mc_ctrl.sv
// Bench for mc_ctrl: each instruction is expanded into its expected per-cycle trace
// from the instruction-level rules, then replayed cycle by cycle against the sequencer.
module tb_mc_ctrl;
    localparam int MEM_TIMEOUT = 15;

    localparam int CAT_R   = 0;
    localparam int CAT_I   = 1;
    localparam int CAT_LW  = 2;
    localparam int CAT_SW  = 3;
    localparam int CAT_BEQ = 4;
    localparam int CAT_BNE = 5;
    localparam int CAT_J   = 6;
    localparam int CAT_JR  = 7;
    localparam int CAT_ILL = 8;
    localparam int NKIND   = 18;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] op, funct;
    logic       equal, mem_rdy;
    logic       IRWr, PCWr, RegDst, RegWr, ExtOp, ALUSrc, MemWr, MemtoReg;
    logic       inst_done, illegal, mem_err;
    logic [2:0] PCSrc, state;
    logic [5:0] ALUCtr;

    always #5 clk = ~clk;

    mc_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .op(op), .funct(funct), .equal(equal), .mem_rdy(mem_rdy),
        .IRWr(IRWr), .PCWr(PCWr), .PCSrc(PCSrc), .RegDst(RegDst), .RegWr(RegWr),
        .ExtOp(ExtOp), .ALUSrc(ALUSrc), .ALUCtr(ALUCtr), .MemWr(MemWr), .MemtoReg(MemtoReg),
        .inst_done(inst_done), .illegal(illegal), .mem_err(mem_err), .state(state)
    );

    typedef struct packed {
        logic       irwr;
        logic       pcwr;
        logic [2:0] pcsrc;
        logic       regdst;
        logic       regwr;
        logic       extop;
        logic       alusrc;
        logic [5:0] aluctr;
        logic       memwr;
        logic       memtoreg;
        logic       done;
        logic       ill;
        logic       merr;
        logic [2:0] st;
    } out_t;

    typedef struct packed {
        logic [5:0] op;
        logic [5:0] funct;
        logic       equal;
        logic       mem_rdy;
        out_t       exp;
    } step_t;

    step_t exp_q[$];
    int    tests = 0;
    int    fails = 0;

    logic [5:0] k_op[NKIND];
    logic [5:0] k_fn[NKIND];
    int         k_cat[NKIND];
    logic [5:0] k_alu[NKIND];
    logic       k_ext[NKIND];
    logic       k_src[NKIND];

    task automatic set_kind(input int i, input logic [5:0] o, input logic [5:0] f, input int c,
                            input logic [5:0] a, input logic e, input logic s);
        k_op[i] = o; k_fn[i] = f; k_cat[i] = c; k_alu[i] = a; k_ext[i] = e; k_src[i] = s;
    endtask

    task automatic init_tab();
        set_kind(0,  6'b000000, 6'b100001, CAT_R,   6'd0, 1'b0, 1'b0);
        set_kind(1,  6'b000000, 6'b100011, CAT_R,   6'd1, 1'b0, 1'b0);
        set_kind(2,  6'b000000, 6'b100100, CAT_R,   6'd2, 1'b0, 1'b0);
        set_kind(3,  6'b000000, 6'b100101, CAT_R,   6'd3, 1'b0, 1'b0);
        set_kind(4,  6'b000000, 6'b101010, CAT_R,   6'd4, 1'b0, 1'b0);
        set_kind(5,  6'b000000, 6'b000000, CAT_R,   6'd5, 1'b0, 1'b0);
        set_kind(6,  6'b000000, 6'b000010, CAT_R,   6'd6, 1'b0, 1'b0);
        set_kind(7,  6'b000000, 6'b001000, CAT_JR,  6'd0, 1'b0, 1'b0);
        set_kind(8,  6'b001001, 6'b000000, CAT_I,   6'd0, 1'b1, 1'b1);
        set_kind(9,  6'b001101, 6'b000000, CAT_I,   6'd3, 1'b0, 1'b1);
        set_kind(10, 6'b001111, 6'b000000, CAT_I,   6'd7, 1'b0, 1'b1);
        set_kind(11, 6'b100011, 6'b000000, CAT_LW,  6'd0, 1'b1, 1'b1);
        set_kind(12, 6'b101011, 6'b000000, CAT_SW,  6'd0, 1'b1, 1'b1);
        set_kind(13, 6'b000100, 6'b000000, CAT_BEQ, 6'd1, 1'b0, 1'b0);
        set_kind(14, 6'b000101, 6'b000000, CAT_BNE, 6'd1, 1'b0, 1'b0);
        set_kind(15, 6'b000010, 6'b000000, CAT_J,   6'd0, 1'b0, 1'b0);
        set_kind(16, 6'b111111, 6'b000000, CAT_ILL, 6'd0, 1'b0, 1'b0);
        set_kind(17, 6'b000000, 6'b111111, CAT_ILL, 6'd0, 1'b0, 1'b0);
    endtask

    task automatic push(input logic [5:0] o, input logic [5:0] f, input logic e, input logic r,
                        input out_t x);
        step_t s;
        s.op = o; s.funct = f; s.equal = e; s.mem_rdy = r; s.exp = x;
        exp_q.push_back(s);
    endtask

    // Expected trace of one instruction; waits = cycles mem_rdy stays low before rising.
    task automatic push_inst(input int k, input logic eq, input int waits);
        out_t       x, sel;
        logic [5:0] fn;
        int         c, n;
        logic       rdy;
        c  = k_cat[k];
        fn = (k_op[k] == 6'd0) ? k_fn[k] : 6'($urandom);
        x = '0; x.irwr = 1'b1; x.st = 3'd0;
        push(6'($urandom), 6'($urandom), 1'($urandom), 1'($urandom), x);
        x = '0; x.st = 3'd1; x.ill = (c == CAT_ILL);
        push(k_op[k], fn, 1'($urandom), 1'($urandom), x);
        sel = '0;
        if (c == CAT_R || c == CAT_I || c == CAT_LW || c == CAT_SW || c == CAT_BEQ || c == CAT_BNE) begin
            sel.aluctr = k_alu[k]; sel.extop = k_ext[k]; sel.alusrc = k_src[k];
        end
        x = sel; x.st = 3'd2;
        if (c == CAT_BEQ || c == CAT_BNE || c == CAT_J || c == CAT_JR || c == CAT_ILL) begin
            x.pcwr = 1'b1; x.done = 1'b1;
        end
        if (c == CAT_BEQ) x.pcsrc = eq ? 3'b001 : 3'b000;
        if (c == CAT_BNE) x.pcsrc = eq ? 3'b000 : 3'b001;
        if (c == CAT_J)   x.pcsrc = 3'b010;
        if (c == CAT_JR)  x.pcsrc = 3'b011;
        push(6'($urandom), 6'($urandom), eq, 1'($urandom), x);
        if (c == CAT_LW || c == CAT_SW) begin
            n = (waits >= MEM_TIMEOUT) ? MEM_TIMEOUT : waits + 1;
            for (int i = 0; i < n; i++) begin
                rdy = (i == waits);
                x = sel; x.st = 3'd3;
                if (rdy && c == CAT_SW) begin
                    x.memwr = 1'b1; x.pcwr = 1'b1; x.done = 1'b1;
                end
                if (!rdy && i == MEM_TIMEOUT - 1) begin
                    x.merr = 1'b1; x.pcwr = 1'b1;
                end
                push(6'($urandom), 6'($urandom), 1'($urandom), rdy, x);
            end
        end
        if (c == CAT_R || c == CAT_I || (c == CAT_LW && waits < MEM_TIMEOUT)) begin
            x = sel; x.st = 3'd4;
            x.regwr = 1'b1; x.regdst = (c == CAT_R); x.memtoreg = (c == CAT_LW);
            x.pcwr = 1'b1; x.done = 1'b1;
            push(6'($urandom), 6'($urandom), 1'($urandom), 1'($urandom), x);
        end
    endtask

    function automatic out_t observed();
        out_t o;
        o = {IRWr, PCWr, PCSrc, RegDst, RegWr, ExtOp, ALUSrc, ALUCtr, MemWr, MemtoReg,
             inst_done, illegal, mem_err, state};
        return o;
    endfunction

    task automatic run_steps(input string tag, input int n, output int pcw);
        step_t s;
        out_t  got;
        pcw = 0;
        for (int i = 0; i < n; i++) begin
            s = exp_q.pop_front();
            @(negedge clk);
            op = s.op; funct = s.funct; equal = s.equal; mem_rdy = s.mem_rdy;
            #1;
            got = observed();
            tests++;
            assert (got === s.exp) else begin
                fails++;
                $error("FAIL %s cycle %0d: got %h required %h", tag, i, got, s.exp);
            end
            tests++;
            assert ((RegWr && MemWr) === 1'b0) else begin
                fails++;
                $error("FAIL %s cycle %0d regwr_memwr_excl: got %b%b required not both", tag, i, RegWr, MemWr);
            end
            if (PCWr === 1'b1) pcw++;
        end
    endtask

    task automatic run_inst(input string tag);
        int pcw;
        run_steps(tag, exp_q.size(), pcw);
        tests++;
        assert (pcw === 1) else begin
            fails++;
            $error("FAIL %s pcwr_count: got %0d required 1", tag, pcw);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        tests++;
        assert (observed() === out_t'(0)) else begin
            fails++;
            $error("FAIL %s: got %h required %h", tag, observed(), out_t'(0));
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int pcw;
        int k;
        init_tab();
        rst = 1'b1; op = '0; funct = '0; equal = 1'b0; mem_rdy = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_outputs("reset_state");
        @(posedge clk); #2 rst = 1'b0;

        push_inst(0, 1'b0, 0);        run_inst("addu");
        push_inst(11, 1'b0, 2);       run_inst("lw_wait2");
        push_inst(13, 1'b1, 0);       run_inst("beq_taken");
        push_inst(13, 1'b0, 0);       run_inst("beq_not_taken");
        push_inst(14, 1'b0, 0);       run_inst("bne_taken");
        push_inst(14, 1'b1, 0);       run_inst("bne_not_taken");
        push_inst(12, 1'b0, 100);     run_inst("sw_timeout");
        push_inst(11, 1'b0, 100);     run_inst("lw_timeout");
        push_inst(12, 1'b0, MEM_TIMEOUT - 1); run_inst("sw_ready_at_limit");
        push_inst(11, 1'b0, MEM_TIMEOUT - 1); run_inst("lw_ready_at_limit");
        push_inst(12, 1'b0, 0);       run_inst("sw_no_wait");
        push_inst(16, 1'b0, 0);       run_inst("illegal_op");
        push_inst(17, 1'b0, 0);       run_inst("illegal_funct");
        push_inst(15, 1'b0, 0);       run_inst("j");
        push_inst(7, 1'b0, 0);        run_inst("jr");
        push_inst(10, 1'b0, 0);       run_inst("lui");

        push_inst(12, 1'b0, 100);
        run_steps("sw_before_rst", 5, pcw);
        exp_q.delete();
        #2 rst = 1'b1;
        #1 check_reset_outputs("rst_mid_mem");
        @(posedge clk); #2 rst = 1'b0;
        push_inst(3, 1'b0, 0);        run_inst("or_after_rst");

        for (int i = 0; i < 150; i++) begin
            k = $urandom_range(0, NKIND - 1);
            push_inst(k, 1'($urandom), ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20)
                                                                    : $urandom_range(0, 2));
            run_inst("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle sequencer for the MIPS CPU datapath (gpr, alu, data_mem, ifu, ext16to32, RegDst/ALUSrc/MemtoReg muxes).
- Replaces the single-cycle ctrl decoder. Splits each instruction into IF/ID/EX/MEM/WB states and gates every write enable so each architectural write occurs in exactly one cycle.
- Adds a memory-ready handshake and a timeout so data_mem can have wait states.

Parameters:
- MEM_TIMEOUT, 15: max cycles spent in MEM waiting for mem_rdy before abort. Legal range 1..255.
- CNT_W, 8: width of the timeout counter.

Ports:
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- op  in  6  inst[31:26], valid from ID onward
- funct  in  6  inst[5:0]
- equal  in  1  ALU compare result (busA==busB), sampled in EX
- mem_rdy  in  1  data_mem completes access this cycle
- IRWr  out  1  latch instruction register
- PCWr  out  1  update PC using PCSrc
- PCSrc  out  3  000 PC+4, 001 branch target, 010 jump, 011 jr (busA)
- RegDst  out  1  1=rd, 0=rt
- RegWr  out  1  GPR write enable
- ExtOp  out  1  1=sign extend, 0=zero extend
- ALUSrc  out  1  1=extended immediate, 0=busB
- ALUCtr  out  6  0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 SLL, 6 SRL, 7 LUI
- MemWr  out  1  data_mem write enable
- MemtoReg  out  1  1=Data_out to busW
- inst_done  out  1  one-cycle pulse when an instruction retires (coincides with PCWr)
- illegal  out  1  one-cycle pulse in ID for an unsupported op/funct
- mem_err  out  1  one-cycle pulse on MEM timeout
- state  out  3  IF=0, ID=1, EX=2, MEM=3, WB=4 (debug)

Behaviour:
- Reset:
  - state=IF, timeout counter=0, latched class=NOP.
  - All enables (IRWr, PCWr, RegWr, MemWr, inst_done, illegal, mem_err) are 0.
  - Datapath selects (PCSrc, RegDst, ExtOp, ALUSrc, ALUCtr, MemtoReg) are 0.
  - Reset asserted in any state aborts immediately with no write.
- Supported instructions:
  - R-type (op 000000), by funct: addu 100001, subu 100011, and 100100, or 100101, slt 101010, sll 000000, srl 000010, jr 001000.
  - I-type/J-type, by op: addiu 001001, ori 001101, lui 001111, lw 100011, sw 101011, beq 000100, bne 000101, j 000010.
- IF:
  - IRWr=1 for one cycle; go to ID.
- ID:
  - Decode op/funct into a registered instruction class.
  - Illegal encoding: pulse illegal; go to EX with class NOP.
  - Otherwise go to EX.
- EX (selects held from EX through WB):
  - ALU ops: set ALUSrc/ExtOp/ALUCtr; go to WB.
  - lw/sw: ALUCtr=ADD, ALUSrc=1, ExtOp=1; clear counter; go to MEM.
  - beq/bne: ALUCtr=SUB; PCWr=1; PCSrc=001 if (beq&equal)|(bne&!equal), else 000; retire; go to IF.
  - j: PCSrc=010, PCWr=1; retire; go to IF.
  - jr: PCSrc=011, PCWr=1; retire; go to IF.
  - NOP: PCSrc=000, PCWr=1; retire; go to IF.
- MEM:
  - Wait while mem_rdy=0; counter increments each cycle.
  - sw: MemWr=1 only in the cycle mem_rdy=1. Then PCWr=1 (PC+4), retire, go to IF.
  - lw: when mem_rdy=1, go to WB.
  - Timeout: if the counter reaches MEM_TIMEOUT with mem_rdy still 0, pulse mem_err, PCWr=1 (PC+4), go to IF. No MemWr, no RegWr. inst_done is not pulsed.
  - mem_rdy=1 in the same cycle the counter hits MEM_TIMEOUT counts as success (ready wins).
- WB:
  - RegWr=1 for exactly one cycle. RegDst=1 for R-type, 0 otherwise. MemtoReg=1 only for lw.
  - Same cycle: PCWr=1, PCSrc=000, retire; go to IF.
- Control output timing:
  - Outputs are decoded combinationally from state plus the registered class and are glitch-free relative to clk edges.
  - op/funct are only consumed in ID; changes to them in later states have no effect.
- Latency with zero-wait memory:
  - R-type / I-ALU: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - branch / j / jr: 3 cycles.
  - illegal: 3 cycles.
- Invariant: at most one of {RegWr, MemWr} is high in any cycle, and PCWr is high exactly once per instruction.

Test Plan:
- addu (op 000000, funct 100001) -> cycles 0..3 state=0,1,2,4. RegWr=1 and RegDst=1 only in cycle 3, with PCWr=1, PCSrc=000, inst_done=1 in that cycle.
- lw (op 100011), mem_rdy held 0 for 2 MEM cycles then 1 -> state 3 for 3 cycles, then WB with RegWr=1, MemtoReg=1, RegDst=0. Total 7 cycles.
- beq equal=1, then beq equal=0, then bne equal=0 -> PCSrc=001, then 000, then 001 in EX with PCWr=1. RegWr and MemWr stay 0 throughout.
- sw, mem_rdy never asserted, MEM_TIMEOUT=15 -> mem_err pulses after 15 MEM cycles. MemWr never asserted, PCWr=1 with PCSrc=000, next state IF.
- op 111111 -> illegal pulses in ID. EX gives PCWr=1, PCSrc=000. No RegWr/MemWr; inst_done=1.
- rst asserted mid-MEM of sw (asynchronous, between edges) -> all outputs 0 immediately and state=0 with no clock edge. After release, the first cycle asserts IRWr=1.
